// File: rtl/bitstream_decoder_pkg.sv
// Shared constants and types for the unary-to-binary bitstream decoder.
//  BITWIDTH : stream precision; one window is WINLEN = 2^BITWIDTH enabled cycles,
//             matching the Sobol RNG period on the encoder side.
//  bitRev   : first-dimension Sobol value for a given index (bit reversal).
package bitstream_decoder_pkg;

  localparam int unsigned BITWIDTH = 4;
  localparam int unsigned WINLEN   = 1 << BITWIDTH;

  typedef enum logic [0:0] {
    StIdle,
    StValid
  } outState_e;

  function automatic logic [BITWIDTH-1:0] bitRev(input logic [BITWIDTH-1:0] idx);
    logic [BITWIDTH-1:0] r;
    for (int i = 0; i < int'(BITWIDTH); i++) begin
      r[i] = idx[BITWIDTH-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/bitstream_decoder_if.sv
// Result handshake between the decoder (master) and its consumer (slave).
//  oData  : decoded count, 0 .. 2^BITWIDTH
//  oValid : oData holds an unconsumed result
//  oDrop  : 1-cycle pulse, an unconsumed result was overwritten
//  iReady : consumer accepts oData when oValid && iReady
interface bitstream_decoder_if;

  logic [bitstream_decoder_pkg::BITWIDTH:0] oData;
  logic                                     oValid;
  logic                                     oDrop;
  logic                                     iReady;

  modport master (
    output oData,
    output oValid,
    output oDrop,
    input  iReady
  );

  modport slave (
    input  oData,
    input  oValid,
    input  oDrop,
    output iReady
  );

endinterface

// File: rtl/bitstream_decoder_cntwithen.sv
// Enabled wrap-around counter; shared with the encoder so both windows stay aligned.
//  iClk  : clock
//  iRstN : asynchronous reset, active low
//  iEn   : count enable
//  iClr  : synchronous clear, overrides iEn
//  oCnt  : current count
module bitstream_decoder_cntwithen #(
  parameter int unsigned Width = 4
) (
  input  logic             iClk,
  input  logic             iRstN,
  input  logic             iEn,
  input  logic             iClr,
  output logic [Width-1:0] oCnt
);

  logic [Width-1:0] cntQ;

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      cntQ <= '0;
    end else if (iClr) begin
      cntQ <= '0;
    end else if (iEn) begin
      cntQ <= cntQ + Width'(1);
    end
  end

  assign oCnt = cntQ;

endmodule

// File: rtl/bitstream_decoder.sv
// Unary-to-binary decoder: counts the 1s of a unary stream over a window of 2^BITWIDTH
// enabled cycles and presents the count through a valid/ready handshake.
//  iClk     : clock
//  iRstN    : asynchronous reset, active low
//  iEn      : stream bit qualifier; the window advances only when set
//  iClr     : synchronous clear of window state and handshake (oData holds)
//  iBit     : unary stream bit
//  oPartial : running count of the current window
//  outIf    : result handshake (oData/oValid/oDrop out, iReady in)
module bitstream_decoder
  import bitstream_decoder_pkg::*;
(
  input  logic                 iClk,
  input  logic                 iRstN,
  input  logic                 iEn,
  input  logic                 iClr,
  input  logic                 iBit,
  output logic [BITWIDTH:0]    oPartial,
  bitstream_decoder_if.master  outIf
);

  localparam logic [BITWIDTH-1:0] WinLast = BITWIDTH'(WINLEN - 1);

  logic [BITWIDTH-1:0] winCnt;
  logic [BITWIDTH:0]   accQ;
  logic [BITWIDTH:0]   accNext;
  logic [BITWIDTH:0]   dataQ;
  logic                dropQ;
  outState_e           stateQ;
  logic                winEnd;

  bitstream_decoder_cntwithen #(
    .Width (BITWIDTH)
  ) uWinCnt (
    .iClk  (iClk),
    .iRstN (iRstN),
    .iEn   (iEn),
    .iClr  (iClr),
    .oCnt  (winCnt)
  );

  // iClr priority is applied in the register block, so winEnd need not qualify it.
  assign winEnd  = iEn && (winCnt == WinLast);
  // acc never exceeds 2^BITWIDTH, so the extra bit is enough and no saturation is needed.
  assign accNext = accQ + (BITWIDTH + 1)'(iBit);

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      accQ   <= '0;
      dataQ  <= '0;
      dropQ  <= 1'b0;
      stateQ <= StIdle;
    end else if (iClr) begin
      accQ   <= '0;
      dropQ  <= 1'b0;
      stateQ <= StIdle;
    end else begin
      dropQ <= 1'b0;
      if (winEnd) begin
        // Final bit is folded in; the next window starts immediately.
        dataQ  <= accNext;
        accQ   <= '0;
        stateQ <= StValid;
        dropQ  <= (stateQ == StValid) && !outIf.iReady;
      end else begin
        if (iEn) begin
          accQ <= accNext;
        end
        if ((stateQ == StValid) && outIf.iReady) begin
          stateQ <= StIdle;
        end
      end
    end
  end

  assign oPartial     = accQ;
  assign outIf.oData  = dataQ;
  assign outIf.oValid = (stateQ == StValid);
  assign outIf.oDrop  = dropQ;

endmodule

// File: tb/tb_bitstream_decoder.sv
module tb_bitstream_decoder;
  import bitstream_decoder_pkg::*;

  typedef struct {
    string             name;
    logic [15:0]       bits;
    logic [15:0]       gaps;
    logic [BITWIDTH:0] expCnt;
  } vec_t;

  logic              iClk = 1'b0;
  logic              iRstN;
  logic              iEn;
  logic              iClr;
  logic              iBit;
  logic [BITWIDTH:0] oPartial;

  bitstream_decoder_if bus ();

  bitstream_decoder dut (
    .iClk     (iClk),
    .iRstN    (iRstN),
    .iEn      (iEn),
    .iClr     (iClr),
    .iBit     (iBit),
    .oPartial (oPartial),
    .outIf    (bus)
  );

  always #5 iClk = ~iClk;

  int                nChecks = 0;
  int                nFails  = 0;
  logic [BITWIDTH:0] expQ[$];
  vec_t              vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Inputs change #1 after a rising edge; results are sampled #1 after the next edge.
  task automatic stepBit(input logic en, input logic b);
    iEn  = en;
    iBit = b;
    @(posedge iClk);
    #1;
  endtask

  task automatic feedBits(input logic [15:0] bits, input logic [15:0] gaps);
    for (int i = 0; i < 16; i++) begin
      if (gaps[i]) stepBit(1'b0, 1'b1);  // stalled 1s must not be counted
      stepBit(1'b1, bits[i]);
    end
    iEn  = 1'b0;
    iBit = 1'b0;
  endtask

  // Returns 1 cycle after the last bit is sampled, with the result already checked.
  task automatic sendWindow(input string name, input logic [15:0] bits, input logic [15:0] gaps,
                            input logic [BITWIDTH:0] expCnt);
    logic [BITWIDTH:0] exp;
    expQ.push_back(expCnt);
    feedBits(bits, gaps);
    check({name, " valid"}, 32'(bus.oValid), 32'd1);
    if (expQ.size() == 0) begin
      check({name, " scoreboard empty"}, 32'd1, 32'd0);
    end else begin
      exp = expQ.pop_front();
      check({name, " data"}, 32'(bus.oData), 32'(exp));
    end
  endtask

  initial begin
    logic [15:0] sobolBits;

    vecs[0] = '{"all ones",   16'hFFFF, 16'h0000, 5'd16};
    vecs[1] = '{"five",       16'h10A5, 16'h0000, 5'd5};
    vecs[2] = '{"five stall", 16'h10A5, 16'h0F0F, 5'd5};
    vecs[3] = '{"zeros",      16'h0000, 16'h0000, 5'd0};
    vecs[4] = '{"alternate",  16'hAAAA, 16'h8001, 5'd8};
    vecs[5] = '{"fifteen",    16'h7FFF, 16'h0000, 5'd15};
    vecs[6] = '{"one last",   16'h8000, 16'h0000, 5'd1};

    iRstN      = 1'b0;
    iEn        = 1'b0;
    iClr       = 1'b0;
    iBit       = 1'b0;
    bus.iReady = 1'b1;

    #12;
    check("reset oData", 32'(bus.oData), 32'd0);
    check("reset oValid", 32'(bus.oValid), 32'd0);
    check("reset oDrop", 32'(bus.oDrop), 32'd0);
    check("reset oPartial", 32'(oPartial), 32'd0);
    @(posedge iClk);
    #1;
    iRstN = 1'b1;

    // Table-driven windows, consumer always ready.
    foreach (vecs[k]) begin
      sendWindow(vecs[k].name, vecs[k].bits, vecs[k].gaps, vecs[k].expCnt);
      check({vecs[k].name, " drop"}, 32'(bus.oDrop), 32'd0);
      stepBit(1'b0, 1'b0);
      check({vecs[k].name, " valid one cycle"}, 32'(bus.oValid), 32'd0);
    end

    // Sobol comparator stream for x=9.
    for (int i = 0; i < 16; i++) sobolBits[i] = (5'd9 > {1'b0, bitRev(4'(i))});
    sendWindow("sobol x9", sobolBits, 16'h0000, 5'd9);
    stepBit(1'b0, 1'b0);

    // Backpressure across two windows: second result overwrites the first.
    bus.iReady = 1'b0;
    sendWindow("bp first", 16'h0007, 16'h0000, 5'd3);
    check("bp first drop", 32'(bus.oDrop), 32'd0);
    sendWindow("bp second", 16'h007F, 16'h0000, 5'd7);
    check("bp second drop", 32'(bus.oDrop), 32'd1);
    stepBit(1'b0, 1'b0);
    check("bp drop pulse ends", 32'(bus.oDrop), 32'd0);
    check("bp still valid", 32'(bus.oValid), 32'd1);
    check("bp data held", 32'(bus.oData), 32'd7);
    bus.iReady = 1'b1;
    stepBit(1'b0, 1'b0);
    check("bp consumed", 32'(bus.oValid), 32'd0);

    // Clear mid-window withdraws a pending result and discards the partial count.
    bus.iReady = 1'b0;
    sendWindow("clr pending", 16'h0003, 16'h0000, 5'd2);
    for (int i = 0; i < 8; i++) stepBit(1'b1, (i < 4) ? 1'b1 : 1'b0);
    check("clr partial before", 32'(oPartial), 32'd4);
    iClr = 1'b1;
    stepBit(1'b1, 1'b1);
    iClr = 1'b0;
    check("clr partial", 32'(oPartial), 32'd0);
    check("clr valid", 32'(bus.oValid), 32'd0);
    check("clr data held", 32'(bus.oData), 32'd2);
    bus.iReady = 1'b1;
    sendWindow("after clr", 16'h0000, 16'h0000, 5'd0);
    stepBit(1'b0, 1'b0);

    // Asynchronous reset mid-window.
    for (int i = 0; i < 10; i++) stepBit(1'b1, (i < 6) ? 1'b1 : 1'b0);
    check("rst partial before", 32'(oPartial), 32'd6);
    #2;
    iRstN = 1'b0;
    #1;
    check("async rst partial", 32'(oPartial), 32'd0);
    check("async rst valid", 32'(bus.oValid), 32'd0);
    check("async rst data", 32'(bus.oData), 32'd0);
    @(posedge iClk);
    #1;
    iRstN = 1'b1;
    sendWindow("after rst", 16'h0301, 16'h0000, 5'd3);
    stepBit(1'b0, 1'b0);
    check("after rst valid", 32'(bus.oValid), 32'd0);
    check("scoreboard drained", 32'(expQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
